// File: rtl/irq_dec_pkg.sv
// Shared widths and FSM encoding for the interrupt decoder/controller.
package irq_dec_pkg;
    localparam int CODE_W_DEF = 2;
    localparam int LINES_DEF  = 2 ** CODE_W_DEF;
    localparam int OVF_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } irq_state_t;
endpackage

// File: rtl/irq_prio_pick.sv
// Combinational highest-index picker: returns the top set bit of req and an any flag.
module irq_prio_pick #(
    parameter int CODE_W = 2,
    parameter int LINES  = 2 ** CODE_W
) (
    input  logic [LINES-1:0]  req,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    always_comb begin
        idx = '0;
        any = |req;
        // Ascending scan so the highest set line is the last writer.
        for (int i = 0; i < LINES; i++) begin
            if (req[i]) idx = i[CODE_W-1:0];
        end
    end
endmodule

// File: rtl/irq_decoder2x4.sv
// Interrupt decoder: sticky pending, per-line mask, claim/EOI handshake to the core.
// Define IRQ_DEC_OVF_EN to add per-line saturating coalesce counters on ovf_cnt.
module irq_decoder2x4
    import irq_dec_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int LINES  = 2 ** CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              valid_in,
    input  logic [LINES-1:0]  mask,
    input  logic              claim,
    input  logic              eoi,
    output logic [LINES-1:0]  pend,
    output logic              irq,
    output logic              in_service,
    output logic [CODE_W-1:0] active_vec
`ifdef IRQ_DEC_OVF_EN
    ,
    output logic [OVF_W*LINES-1:0] ovf_cnt
`endif
);
    irq_state_t        state_q, state_d;
    logic [LINES-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] active_q, active_d;
    logic [LINES-1:0]  set_vec;
    logic [LINES-1:0]  clr_vec;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic              grant;

    irq_prio_pick #(
        .CODE_W (CODE_W),
        .LINES  (LINES)
    ) u_pick (
        .req (pend_q & ~mask),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant = (state_q == PEND) && claim && pick_any;

    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        state_d  = state_q;
        active_d = active_q;
        if (valid_in) set_vec[code_in] = 1'b1;
        if (grant)    clr_vec[pick_idx] = 1'b1;
        // Set is applied after clear so a same-cycle request survives its own claim.
        pend_d = (pend_q & ~clr_vec) | set_vec;

        case (state_q)
            IDLE: if (|pend_d) state_d = PEND;
            PEND: begin
                if (grant) begin
                    state_d  = SERV;
                    active_d = pick_idx;
                end
            end
            SERV: begin
                if (eoi) state_d = (|pend_d) ? PEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    assign pend       = pend_q;
    assign in_service = (state_q == SERV);
    assign active_vec = active_q;
    assign irq        = (state_q != SERV) && (|(pend_q & ~mask));

`ifdef IRQ_DEC_OVF_EN
    logic [OVF_W-1:0] ovf_q [LINES];

    for (genvar n = 0; n < LINES; n++) begin : g_ovf
        logic hit;
        assign hit = valid_in && (code_in == CODE_W'(n)) &&
                     (pend_q[n] || ((state_q == SERV) && (active_q == CODE_W'(n))));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q[n] <= '0;
            end else if (clr_vec[n]) begin
                ovf_q[n] <= '0;
            end else if (hit && (ovf_q[n] != {OVF_W{1'b1}})) begin
                ovf_q[n] <= ovf_q[n] + 1'b1;
            end
        end

        assign ovf_cnt[n*OVF_W +: OVF_W] = ovf_q[n];
    end
`endif
endmodule

// File: tb/tb_irq_decoder2x4.sv
// Directed bench for irq_decoder2x4: vector table plus hand sequences for reset and coalescing.
module tb_irq_decoder2x4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] code_in;
    logic       valid_in;
    logic [3:0] mask;
    logic       claim;
    logic       eoi;
    logic [3:0] pend;
    logic       irq;
    logic       in_service;
    logic [1:0] active_vec;
`ifdef IRQ_DEC_OVF_EN
    logic [15:0] ovf_cnt;
`endif

    irq_decoder2x4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .valid_in   (valid_in),
        .mask       (mask),
        .claim      (claim),
        .eoi        (eoi),
        .pend       (pend),
        .irq        (irq),
        .in_service (in_service),
        .active_vec (active_vec)
`ifdef IRQ_DEC_OVF_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] code;
        logic [3:0] msk;
        logic       clm;
        logic       eo;
        logic [3:0] e_pend;
        logic       e_irq;
        logic       e_insv;
        logic [1:0] e_act;
    } vec_t;

    vec_t tbl[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(logic v, logic [1:0] c, logic [3:0] m, logic cl, logic e,
                                logic [3:0] ep, logic ei, logic es, logic [1:0] ea);
        vec_t r;
        r.valid = v; r.code = c; r.msk = m; r.clm = cl; r.eo = e;
        r.e_pend = ep; r.e_irq = ei; r.e_insv = es; r.e_act = ea;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] m,
                         input logic cl, input logic e);
        valid_in = v; code_in = c; mask = m; claim = cl; eoi = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] ep, input logic ei,
                            input logic es, input logic [1:0] ea);
        chk({tag, ".pend"}, 32'(pend), 32'(ep));
        chk({tag, ".irq"}, 32'(irq), 32'(ei));
        chk({tag, ".in_service"}, 32'(in_service), 32'(es));
        chk({tag, ".active_vec"}, 32'(active_vec), 32'(ea));
    endtask

    initial begin
        //             v  code  mask     clm  eoi  pend     irq  insv act
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0)); // idle
        tbl.push_back(mk(1, 2'd2, 4'b0000, 0, 0, 4'b0100, 1, 0, 2'd0)); // first request
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0000, 0, 1, 2'd2)); // claim 2
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd2)); // eoi -> IDLE
        tbl.push_back(mk(1, 2'd3, 4'b0000, 0, 0, 4'b1000, 1, 0, 2'd2));
        tbl.push_back(mk(1, 2'd1, 4'b0000, 0, 0, 4'b1010, 1, 0, 2'd2));
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0010, 0, 1, 2'd3)); // priority claim 3
        tbl.push_back(mk(1, 2'd0, 4'b0000, 0, 0, 4'b0011, 0, 1, 2'd3)); // request in SERV
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0011, 0, 1, 2'd3)); // claim in SERV ignored
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b0011, 1, 0, 2'd3)); // eoi -> PEND
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 1, 4'b0001, 0, 1, 2'd1)); // eoi ignored in PEND
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 1, 4'b0001, 1, 0, 2'd1)); // claim+eoi in SERV
        tbl.push_back(mk(0, 2'd0, 4'b0001, 0, 0, 4'b0001, 0, 0, 2'd1)); // masked
        tbl.push_back(mk(0, 2'd0, 4'b0001, 1, 0, 4'b0001, 0, 0, 2'd1)); // masked claim ignored
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 0, 4'b0001, 1, 0, 2'd1));
        tbl.push_back(mk(1, 2'd3, 4'b1000, 0, 0, 4'b1001, 1, 0, 2'd1));
        tbl.push_back(mk(0, 2'd0, 4'b1000, 1, 0, 4'b1000, 0, 1, 2'd0)); // mask skips line 3
        tbl.push_back(mk(0, 2'd0, 4'b1000, 0, 1, 4'b1000, 0, 0, 2'd0));
        tbl.push_back(mk(0, 2'd0, 4'b1001, 1, 0, 4'b1000, 0, 0, 2'd0)); // nothing unmasked
        tbl.push_back(mk(1, 2'd1, 4'b0000, 0, 0, 4'b1010, 1, 0, 2'd0));
        tbl.push_back(mk(1, 2'd1, 4'b1000, 1, 0, 4'b1010, 0, 1, 2'd1)); // set wins over claim
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b1010, 1, 0, 2'd1));
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0010, 0, 1, 2'd3));
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b0010, 1, 0, 2'd3));
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0000, 0, 1, 2'd1)); // claim right after eoi
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd1));
        tbl.push_back(mk(0, 2'd0, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd1)); // eoi in IDLE
        tbl.push_back(mk(0, 2'd0, 4'b0000, 1, 0, 4'b0000, 0, 0, 2'd1)); // claim in IDLE

        drive(0, 2'd0, 4'b0000, 0, 0);
        rst_n = 1'b0;
        #12;
        chk_outs("reset", 4'b0000, 0, 0, 2'd0);
`ifdef IRQ_DEC_OVF_EN
        chk("reset.ovf_cnt", 32'(ovf_cnt), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].valid, tbl[i].code, tbl[i].msk, tbl[i].clm, tbl[i].eo);
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].e_pend, tbl[i].e_irq,
                     tbl[i].e_insv, tbl[i].e_act);
        end

        // Mask changes reach irq without a clock edge.
        drive(1, 2'd2, 4'b0000, 0, 0);
        step();
        drive(0, 2'd0, 4'b0000, 0, 0);
        #1;
        chk("mask_comb.on", 32'(irq), 32'd1);
        mask = 4'b0100;
        #1;
        chk("mask_comb.off", 32'(irq), 32'd0);
        mask = 4'b0000;
        #1;
        chk("mask_comb.back", 32'(irq), 32'd1);

        // Build pend=0110 while servicing line 3, then reset mid-service.
        drive(1, 2'd1, 4'b0000, 0, 0); step();
        drive(1, 2'd3, 4'b0000, 0, 0); step();
        drive(0, 2'd0, 4'b0000, 1, 0); step();
        drive(0, 2'd0, 4'b0000, 0, 0);
        chk_outs("pre_rst", 4'b0110, 0, 1, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("mid_rst", 4'b0000, 0, 0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_outs("post_rst", 4'b0000, 0, 0, 2'd0);
        drive(0, 2'd0, 4'b0000, 1, 0); step();
        chk_outs("post_rst.claim", 4'b0000, 0, 0, 2'd0);
        drive(1, 2'd0, 4'b0000, 0, 0); step();
        chk_outs("post_rst.req", 4'b0001, 1, 0, 2'd0);

`ifdef IRQ_DEC_OVF_EN
        // Line 0 is already pending, so each further request is coalesced.
        for (int i = 0; i < 20; i++) begin
            drive(1, 2'd0, 4'b0000, 0, 0);
            step();
        end
        drive(0, 2'd0, 4'b0000, 0, 0);
        chk("ovf.sat", 32'(ovf_cnt), 32'h000F);
        drive(0, 2'd0, 4'b0000, 1, 0); step();
        chk("ovf.claim_clr", 32'(ovf_cnt), 32'h0000);
        chk("ovf.claim_act", 32'(active_vec), 32'd0);
        drive(1, 2'd0, 4'b0000, 0, 0); step();
        chk("ovf.active_hit", 32'(ovf_cnt), 32'h0001);
        drive(1, 2'd2, 4'b0000, 0, 0); step();
        chk("ovf.fresh_line", 32'(ovf_cnt), 32'h0001);
        drive(0, 2'd0, 4'b0000, 0, 1); step();
        drive(0, 2'd0, 4'b0000, 0, 0);
        chk_outs("ovf.after_eoi", 4'b0101, 1, 0, 2'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
